ssb_xbar: RTL and testbench

SSB_XBAR -- requirements
Module: ssb_xbar

---
 rtl/ssb_pkg.sv | 18 +
 rtl/ssb_rr_arbiter.sv | 49 ++++
 rtl/ssb_xbar.sv | 152 +++++++++++++++
 tb/tb_ssb_xbar.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ssb_pkg.sv
// Shared types and limits for the simple-bus crossbar.
package ssb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned MAX_HOSTS       = 8;
  localparam int unsigned MAX_DEVICES     = 8;
  localparam int unsigned MAX_OUTSTANDING = 8;

  // Index width that stays legal for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssb_rr_arbiter.sv
// Host arbiter: combinational winner selection, fixed-priority or round-robin.
// rr_ptr only advances on an accepted request.
module ssb_rr_arbiter
  import ssb_pkg::*;
#(
  parameter int unsigned NrHosts = 3,
  parameter arb_mode_e   Mode    = ARB_FIXED,
  localparam int unsigned IdxW   = idx_width(NrHosts)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrHosts-1:0] req_i,
  input  logic               accept_i,
  output logic [IdxW-1:0]    winner_o,
  output logic               valid_o
);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  int unsigned     base_idx;
  int unsigned     cand;

  // Scan from highest offset down so the smallest offset from the base wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = 0;
    base_idx = (Mode == ARB_RR) ? int'(rr_ptr_q) : 0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      cand = (base_idx + i) % NrHosts;
      if (req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = IdxW'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (Mode == ARB_RR && accept_i && valid_o) begin
      rr_ptr_d = (int'(winner_o) == NrHosts - 1) ? '0 : winner_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ssb_xbar.sv
// N-host to M-device simple-bus crossbar with in-order response tracking.
// Grant is combinational in the request cycle; earliest response is the following cycle.
module ssb_xbar
  import ssb_pkg::*;
#(
  parameter int unsigned NrHosts        = 3,
  parameter int unsigned NrDevices      = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter arb_mode_e   ArbMode        = ARB_FIXED,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [NrDevices-1:0][AddrWidth-1:0] DevBase = '0,
  parameter logic [NrDevices-1:0][AddrWidth-1:0] DevMask = '0,
  localparam int unsigned BeWidth       = DataWidth / 8
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_sys_i,
  input  logic [NrHosts-1:0]                 host_req_i,
  input  logic [NrHosts-1:0]                 host_we_i,
  input  logic [NrHosts-1:0][AddrWidth-1:0]  host_addr_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]  host_wdata_i,
  input  logic [NrHosts-1:0][BeWidth-1:0]    host_be_i,
  output logic [NrHosts-1:0]                 host_gnt_o,
  output logic [NrHosts-1:0]                 host_rvalid_o,
  output logic [NrHosts-1:0]                 host_err_o,
  output logic [DataWidth-1:0]               host_rdata_o,
  output logic [NrDevices-1:0]               dev_req_o,
  output logic [AddrWidth-1:0]               dev_addr_o,
  output logic                               dev_we_o,
  output logic [BeWidth-1:0]                 dev_be_o,
  output logic [DataWidth-1:0]               dev_wdata_o,
  input  logic [NrDevices-1:0]               dev_gnt_i,
  input  logic [NrDevices-1:0]               dev_rvalid_i,
  input  logic [NrDevices-1:0]               dev_err_i,
  input  logic [NrDevices-1:0][DataWidth-1:0] dev_rdata_i
);

  localparam int unsigned HIdxW = idx_width(NrHosts);
  localparam int unsigned DIdxW = idx_width(NrDevices);
  localparam int unsigned PtrW  = idx_width(MaxOutstanding);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [HIdxW-1:0] host;
    logic [DIdxW-1:0] dev;
    logic             unmapped;
  } trk_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  logic [HIdxW-1:0] win_idx;
  logic             win_vld;
  logic [DIdxW-1:0] dev_sel;
  logic             mapped, full, empty, accept, resp;
  trk_t             mem_q [MaxOutstanding];
  trk_t             head;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  ssb_rr_arbiter #(
    .NrHosts (NrHosts),
    .Mode    (ArbMode)
  ) u_arb (
    .clk_i    (clk_sys_i),
    .rst_i    (rst_sys_i),
    .req_i    (host_req_i),
    .accept_i (accept),
    .winner_o (win_idx),
    .valid_o  (win_vld)
  );

  // Shared request bus follows the winner; idle bus is driven to zero.
  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    if (win_vld) begin
      dev_addr_o  = host_addr_i[win_idx];
      dev_we_o    = host_we_i[win_idx];
      dev_be_o    = host_be_i[win_idx];
      dev_wdata_o = host_wdata_i[win_idx];
    end
  end

  always_comb begin
    mapped  = 1'b0;
    dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (win_vld && ((dev_addr_o & ~DevMask[d]) == DevBase[d])) begin
        mapped  = 1'b1;
        dev_sel = DIdxW'(d);
      end
    end
  end

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CntW'(MaxOutstanding));
  assign accept = !rst_sys_i && win_vld && !full && (!mapped || dev_gnt_i[dev_sel]);
  assign head   = mem_q[rd_ptr_q];
  assign resp   = !empty && (head.unmapped || dev_rvalid_i[head.dev]);

  always_comb begin
    dev_req_o  = '0;
    host_gnt_o = '0;
    if (!rst_sys_i && win_vld && mapped && !full) dev_req_o[dev_sel] = 1'b1;
    if (accept) host_gnt_o[win_idx] = 1'b1;
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (resp) begin
      host_rvalid_o[head.host] = 1'b1;
      if (head.unmapped) begin
        host_err_o[head.host] = 1'b1;
      end else begin
        host_err_o[head.host] = dev_err_i[head.dev];
        host_rdata_o          = dev_rdata_i[head.dev];
      end
    end
  end

  always_comb begin
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = resp ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept && !resp)      cnt_d = cnt_q + 1'b1;
    else if (!accept && resp) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage needs no reset; validity is carried by cnt_q.
  always_ff @(posedge clk_sys_i) begin
    if (accept) mem_q[wr_ptr_q] <= '{host: win_idx, dev: dev_sel, unmapped: !mapped};
  end

endmodule

// File: tb/tb_ssb_xbar.sv
// Directed bench for ssb_xbar: a fixed-priority and a round-robin instance share stimulus.
module tb_ssb_xbar;
  import ssb_pkg::*;

  logic                 clk, rst;
  logic [2:0]           host_req, host_we;
  logic [2:0][31:0]     host_addr, host_wdata;
  logic [2:0][3:0]      host_be;
  logic [1:0]           dev_gnt, dev_rvalid, dev_err;
  logic [1:0][31:0]     dev_rdata;

  logic [2:0]  gnt_f, rv_f, err_f, gnt_r, rv_r, err_r;
  logic [31:0] rdata_f, rdata_r, dev_addr_f, dev_addr_r, dev_wdata_f, dev_wdata_r;
  logic [1:0]  dev_req_f, dev_req_r;
  logic        dev_we_f, dev_we_r;
  logic [3:0]  dev_be_f, dev_be_r;

  typedef struct {
    int          host;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  logic [2:0] oh;
  bit   sb_en;
  int   checks, errors;

  localparam logic [1:0][31:0] BASE = {32'h1A11_0000, 32'h0000_0000};
  localparam logic [1:0][31:0] MASK = {32'h0000_FFFF, 32'h0000_FFFF};

  ssb_xbar #(.ArbMode(ARB_FIXED), .DevBase(BASE), .DevMask(MASK)) u_fix (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_gnt_o(gnt_f), .host_rvalid_o(rv_f), .host_err_o(err_f), .host_rdata_o(rdata_f),
    .dev_req_o(dev_req_f), .dev_addr_o(dev_addr_f), .dev_we_o(dev_we_f),
    .dev_be_o(dev_be_f), .dev_wdata_o(dev_wdata_f),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
  );

  ssb_xbar #(.ArbMode(ARB_RR), .DevBase(BASE), .DevMask(MASK)) u_rr (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_gnt_o(gnt_r), .host_rvalid_o(rv_r), .host_err_o(err_r), .host_rdata_o(rdata_r),
    .dev_req_o(dev_req_r), .dev_addr_o(dev_addr_r), .dev_we_o(dev_we_r),
    .dev_be_o(dev_be_r), .dev_wdata_o(dev_wdata_r),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int h, input logic er, input logic [31:0] d);
    exp_t x;
    x.host = h;
    x.err  = er;
    x.data = d;
    sb_q.push_back(x);
  endtask

  // Response monitor: every host_rvalid_o of the fixed instance must match the queue head.
  always @(negedge clk) begin
    if (sb_en && rv_f != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rvalid", {61'd0, rv_f}, 64'd0);
      end else begin
        e  = sb_q.pop_front();
        oh = 3'b001 << e.host;
        chk("rsp_host", {61'd0, rv_f}, {61'd0, oh});
        chk("rsp_err", {61'd0, err_f}, e.err ? {61'd0, oh} : 64'd0);
        chk("rsp_rdata", {32'd0, rdata_f}, {32'd0, e.data});
      end
    end
  end

  initial begin
    checks = 0; errors = 0; sb_en = 1'b1;
    rst = 1'b1;
    host_req = 3'b001; host_we = '0; host_addr = '0; host_wdata = '0; host_be = '0;
    dev_gnt = 2'b11; dev_rvalid = '0; dev_err = '0; dev_rdata = '0;

    // Reset: requests and grants are suppressed, response outputs idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {61'd0, gnt_f}, 64'd0);
    chk("rst_dev_req", {62'd0, dev_req_f}, 64'd0);
    chk("rst_rvalid", {61'd0, rv_f | rv_r}, 64'd0);
    chk("rst_err", {61'd0, err_f}, 64'd0);
    chk("rst_rdata", {32'd0, rdata_f}, 64'd0);
    tick(); rst = 1'b0; host_req = '0;

    // Fixed priority: hosts 0 and 2 together.
    tick(); host_req = 3'b101; host_addr[0] = 32'h10; host_addr[2] = 32'h20;
    push_exp(0, 1'b0, 32'hA0);
    @(negedge clk);
    chk("fix_gnt_h0", {61'd0, gnt_f}, 64'b001);
    chk("fix_dev_req", {62'd0, dev_req_f}, 64'b01);
    chk("fix_addr_h0", {32'd0, dev_addr_f}, 64'h10);
    tick(); host_req = 3'b100; dev_rvalid = 2'b01; dev_rdata[0] = 32'hA0;
    push_exp(2, 1'b0, 32'hA1);
    @(negedge clk);
    chk("fix_gnt_h2", {61'd0, gnt_f}, 64'b100);
    chk("fix_addr_h2", {32'd0, dev_addr_f}, 64'h20);
    tick(); host_req = '0; dev_rdata[0] = 32'hA1;
    @(negedge clk);
    chk("idle_addr", {32'd0, dev_addr_f}, 64'd0);
    chk("idle_dev_req", {62'd0, dev_req_f}, 64'd0);
    tick(); dev_rvalid = '0;

    // Unmapped read, then a device-1 read answered with an error, non-head rvalid ignored.
    tick(); host_req = 3'b001; host_addr[0] = 32'h2000_0000; dev_rdata = '1;
    push_exp(0, 1'b1, 32'h0);
    @(negedge clk);
    chk("unm_gnt", {61'd0, gnt_f}, 64'b001);
    chk("unm_no_dev_req", {62'd0, dev_req_f}, 64'd0);
    tick(); host_req = 3'b100; host_addr[2] = 32'h1A11_0004;
    push_exp(2, 1'b1, 32'hC0);
    @(negedge clk);
    chk("dev1_gnt", {61'd0, gnt_f}, 64'b100);
    chk("dev1_req", {62'd0, dev_req_f}, 64'b10);
    tick(); host_req = '0; dev_rvalid = 2'b11; dev_rdata[1] = 32'hC0; dev_err = 2'b10;
    tick(); dev_rvalid = '0; dev_err = '0;

    // Tracking FIFO full: third request stalls until a response frees a slot.
    dev_gnt = 2'b01;
    tick(); host_req = 3'b001; host_addr[0] = 32'h100;
    push_exp(0, 1'b0, 32'hB0);
    @(negedge clk); chk("full_acc1", {61'd0, gnt_f}, 64'b001);
    tick(); push_exp(0, 1'b0, 32'hB1);
    @(negedge clk); chk("full_acc2", {61'd0, gnt_f}, 64'b001);
    tick();
    @(negedge clk);
    chk("full_stall_gnt", {61'd0, gnt_f}, 64'd0);
    chk("full_stall_req", {62'd0, dev_req_f}, 64'd0);
    tick(); dev_rvalid = 2'b01; dev_rdata[0] = 32'hB0;
    @(negedge clk); chk("full_pop_still_blocked", {61'd0, gnt_f}, 64'd0);
    tick(); dev_rvalid = '0; push_exp(0, 1'b0, 32'hB2);
    @(negedge clk); chk("full_acc3", {61'd0, gnt_f}, 64'b001);
    tick(); host_req = '0; dev_rvalid = 2'b01; dev_rdata[0] = 32'hB1;
    tick(); dev_rdata[0] = 32'hB2;
    tick(); dev_rvalid = '0;

    // In-order return: host 0 read then host 1 write to device 0.
    tick(); host_req = 3'b011; host_addr[0] = 32'h40; host_addr[1] = 32'h44;
    host_we = 3'b010; host_wdata[1] = 32'hCAFE_F00D; host_be[1] = 4'b0011;
    push_exp(0, 1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("ord_gnt_h0", {61'd0, gnt_f}, 64'b001);
    chk("ord_we_h0", {63'd0, dev_we_f}, 64'd0);
    tick(); host_req = 3'b010; dev_rvalid = 2'b01; dev_rdata[0] = 32'h1234_5678;
    push_exp(1, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ord_gnt_h1", {61'd0, gnt_f}, 64'b010);
    chk("ord_we_h1", {63'd0, dev_we_f}, 64'd1);
    chk("ord_wdata_h1", {32'd0, dev_wdata_f}, 64'hCAFE_F00D);
    chk("ord_be_h1", {60'd0, dev_be_f}, 64'h3);
    tick(); host_req = '0; host_we = '0; dev_rdata[0] = 32'hDEAD_BEEF;
    tick(); dev_rvalid = '0;
    @(negedge clk); chk("sb_drained_1", sb_q.size(), 64'd0);

    // Reset with two outstanding entries; late device response must be dropped.
    tick(); host_req = 3'b001; host_addr[0] = 32'h80;
    @(negedge clk); chk("rst_mid_acc1", {61'd0, gnt_f}, 64'b001);
    tick();
    @(negedge clk); chk("rst_mid_acc2", {61'd0, gnt_f}, 64'b001);
    tick(); host_req = '0; rst = 1'b1;
    @(negedge clk); chk("rst_mid_rvalid", {61'd0, rv_f}, 64'd0);
    tick(); rst = 1'b0;
    tick(); dev_rvalid = 2'b01; dev_rdata[0] = 32'h77;
    @(negedge clk); chk("late_rsp_ignored", {61'd0, rv_f}, 64'd0);
    tick(); dev_rvalid = '0; host_req = 3'b001; push_exp(0, 1'b0, 32'h88);
    @(negedge clk); chk("post_rst_gnt", {61'd0, gnt_f}, 64'b001);
    tick(); host_req = '0; dev_rvalid = 2'b01; dev_rdata[0] = 32'h88;
    tick(); dev_rvalid = '0;
    @(negedge clk); chk("sb_drained_2", sb_q.size(), 64'd0);

    // Round-robin instance: all hosts request, device grants and answers every cycle.
    sb_en = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick(); host_req = 3'b111; host_addr = '0; dev_gnt = 2'b01; dev_rvalid = 2'b01;
    @(negedge clk); chk("rr_gnt0", {61'd0, gnt_r}, 64'b001);
    tick(); @(negedge clk); chk("rr_gnt1", {61'd0, gnt_r}, 64'b010);
    tick(); @(negedge clk); chk("rr_gnt2", {61'd0, gnt_r}, 64'b100);
    tick(); @(negedge clk); chk("rr_wrap", {61'd0, gnt_r}, 64'b001);
    tick(); dev_gnt = 2'b00;
    @(negedge clk);
    chk("rr_nogrant_gnt", {61'd0, gnt_r}, 64'd0);
    chk("rr_nogrant_req", {62'd0, dev_req_r}, 64'b01);
    tick(); dev_gnt = 2'b01;
    @(negedge clk); chk("rr_ptr_held", {61'd0, gnt_r}, 64'b010);
    tick(); host_req = '0; dev_rvalid = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
